// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/busy/done handshake feeding a status register.
// Optional feature macro: SEQ_ALU_MUL_EN (iterative shift-add multiplier for op 111).
// Without it, op 111 completes in one cycle with result 0 and Z=1.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             Z_out,
   output logic             N_out,
   output logic             C_out,
   output logic             V_out,
   output logic             load_flags
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
      OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
   } op_t;

   state_t           state, state_nx;
   op_t              op_r;
   logic [WIDTH-1:0] a_r, b_r;
   logic [CW-1:0]    cnt;
   logic             sh_en;
   logic [SW-1:0]    k;
   logic             last;
   logic             is_shift;

   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] sh_res;
   logic             sh_out;
   logic [WIDTH-1:0] fin_res;
   logic             fin_c, fin_v;

`ifdef SEQ_ALU_MUL_EN
   logic [2*WIDTH-1:0] prod, prod_nx;
   logic [WIDTH:0]     mul_sum;
`endif

   assign k          = b[SW-1:0];
   assign last       = (cnt == CW'(1));
   assign is_shift   = (op_r == OP_SHL) || (op_r == OP_SHR);
   assign load_flags = done;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = EXEC;
         EXEC: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Per-cycle arithmetic and final result/flag selection
   always_comb begin
      sum     = {1'b0, a_r} + {1'b0, b_r};
      diff    = {1'b0, a_r} - {1'b0, b_r};
      sh_res  = a_r;
      sh_out  = 1'b0;
      fin_res = '0;
      fin_c   = 1'b0;
      fin_v   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
      // Right-shifting product: upper half accumulates, lower half holds the remaining multiplier bits
      mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
      prod_nx = {mul_sum, prod[WIDTH-1:1]};
`endif
      if (op_r == OP_SHL) begin
         sh_res = {a_r[WIDTH-2:0], 1'b0};
         sh_out = a_r[WIDTH-1];
      end else begin
         sh_res = {1'b0, a_r[WIDTH-1:1]};
         sh_out = a_r[0];
      end
      case (op_r)
         OP_ADD: begin
            fin_res = sum[WIDTH-1:0];
            fin_c   = sum[WIDTH];
            fin_v   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
         end
         OP_SUB: begin
            fin_res = diff[WIDTH-1:0];
            fin_c   = ~diff[WIDTH];
            fin_v   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff[WIDTH-1] != a_r[WIDTH-1]);
         end
         OP_AND: fin_res = a_r & b_r;
         OP_OR:  fin_res = a_r | b_r;
         OP_XOR: fin_res = a_r ^ b_r;
         OP_SHL, OP_SHR: begin
            fin_res = sh_en ? sh_res : a_r;
            fin_c   = sh_en ? sh_out : 1'b0;
         end
`ifdef SEQ_ALU_MUL_EN
         OP_MUL: begin
            fin_res = prod_nx[WIDTH-1:0];
            fin_c   = |prod_nx[2*WIDTH-1:WIDTH];
         end
`endif
         default: ;
      endcase
   end

   // Operand capture, iteration and registered result/flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r   <= OP_ADD;
         a_r    <= '0;
         b_r    <= '0;
         cnt    <= '0;
         sh_en  <= 1'b0;
         result <= '0;
         Z_out  <= 1'b0;
         N_out  <= 1'b0;
         C_out  <= 1'b0;
         V_out  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         prod   <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               op_r  <= op_t'(op);
               a_r   <= a;
               b_r   <= b;
               sh_en <= (k != '0);
               if ((op_t'(op) == OP_SHL) || (op_t'(op) == OP_SHR))
                  cnt <= (k == '0) ? CW'(1) : CW'(k);
`ifdef SEQ_ALU_MUL_EN
               else if (op_t'(op) == OP_MUL)
                  cnt <= CW'(WIDTH);
`endif
               else
                  cnt <= CW'(1);
`ifdef SEQ_ALU_MUL_EN
               prod <= {{WIDTH{1'b0}}, b};
`endif
            end
            EXEC: begin
               cnt <= cnt - CW'(1);
               if (is_shift && sh_en) a_r <= sh_res;
`ifdef SEQ_ALU_MUL_EN
               prod <= prod_nx;
`endif
               if (last) begin
                  result <= fin_res;
                  Z_out  <= (fin_res == '0);
                  N_out  <= fin_res[WIDTH-1];
                  C_out  <= fin_c;
                  V_out  <= fin_v;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed scoreboard bench for seq_alu (WIDTH=8), both SEQ_ALU_MUL_EN builds.
module tb_seq_alu;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] op = '0;
   logic [7:0] a = '0, b = '0;
   logic       busy, done, Z_out, N_out, C_out, V_out, load_flags;
   logic [7:0] result;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] res;
      logic z, n, c, v;
      int lat;
      int acc;
      string tag;
   } exp_t;

   exp_t q[$];

   seq_alu #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result),
      .Z_out(Z_out), .N_out(N_out), .C_out(C_out), .V_out(V_out),
      .load_flags(load_flags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(string tag, logic [2:0] o, logic [7:0] x, logic [7:0] y);
      exp_t e;
      int s, sv, k, p;
      e.tag = tag; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0; e.res = '0;
      k = int'(y[2:0]);
      p = 0; s = 0; sv = 0;
      case (o)
         3'd0: begin
            s = int'(x) + int'(y); e.res = s[7:0]; e.c = (s > 255);
            sv = int'($signed(x)) + int'($signed(y)); e.v = (sv > 127) || (sv < -128);
         end
         3'd1: begin
            s = int'(x) - int'(y); e.res = s[7:0]; e.c = (x >= y);
            sv = int'($signed(x)) - int'($signed(y)); e.v = (sv > 127) || (sv < -128);
         end
         3'd2: e.res = x & y;
         3'd3: e.res = x | y;
         3'd4: e.res = x ^ y;
         3'd5: begin
            e.res = 8'(x << k); e.c = (k != 0) ? x[8-k] : 1'b0; e.lat = (k == 0) ? 1 : k;
         end
         3'd6: begin
            e.res = x >> k; e.c = (k != 0) ? x[k-1] : 1'b0; e.lat = (k == 0) ? 1 : k;
         end
         default: begin
`ifdef SEQ_ALU_MUL_EN
            p = int'(x) * int'(y); e.res = p[7:0]; e.c = (p > 255); e.lat = 8;
`else
            e.res = '0;
`endif
         end
      endcase
      e.z = (e.res == 8'h00);
      e.n = e.res[7];
      return e;
   endfunction

   // Scoreboard consumer: every completion must match the oldest outstanding operation
   always @(negedge clk) begin
      if (reset === 1'b0 && done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_done", done, 1'b0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, "_res"}, result, e.res);
            chk({e.tag, "_flags"}, {Z_out, N_out, C_out, V_out}, {e.z, e.n, e.c, e.v});
            chk({e.tag, "_lat"}, cyc - e.acc, e.lat);
            chk({e.tag, "_ldf"}, load_flags, 1'b1);
         end
      end
   end

   task automatic issue(string tag, logic [2:0] o, logic [7:0] x, logic [7:0] y);
      exp_t e;
      @(negedge clk);
      e = model(tag, o, x, y);
      e.acc = cyc + 1;
      q.push_back(e);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
   endtask

   task automatic wait_done(string tag);
      int n = 0;
      while ((q.size() != 0 || busy === 1'b1) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, (n < 60), 1'b1);
      repeat (3) @(negedge clk);
   endtask

   logic [2:0] long_op;
   logic [7:0] long_b;

   initial begin
`ifdef SEQ_ALU_MUL_EN
      long_op = 3'b111; long_b = 8'h11;
`else
      long_op = 3'b101; long_b = 8'h07;
`endif
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", {done, load_flags}, 2'b00);
      chk("rst_result", result, 8'h00);
      chk("rst_flags", {Z_out, N_out, C_out, V_out}, 4'b0000);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      issue("add_ovf", 3'b000, 8'h7F, 8'h01);   wait_done("add_ovf");
      chk("result_held", result, 8'h80);
      issue("sub_eq", 3'b001, 8'h05, 8'h05);    wait_done("sub_eq");
      issue("sub_brw", 3'b001, 8'h00, 8'h01);   wait_done("sub_brw");
      issue("add_cy", 3'b000, 8'hF0, 8'h20);    wait_done("add_cy");
      issue("sub_ovf", 3'b001, 8'h80, 8'h01);   wait_done("sub_ovf");
      issue("and", 3'b010, 8'hF0, 8'h3C);       wait_done("and");
      issue("or", 3'b011, 8'h81, 8'h18);        wait_done("or");
      issue("xor", 3'b100, 8'hAA, 8'hAA);       wait_done("xor");
      issue("shl3", 3'b101, 8'h81, 8'h03);      wait_done("shl3");
      issue("shr1", 3'b110, 8'h81, 8'h01);      wait_done("shr1");
      issue("shl0", 3'b101, 8'h81, 8'h00);      wait_done("shl0");
      issue("shr7", 3'b110, 8'h80, 8'hF7);      wait_done("shr7");
      issue("mul", 3'b111, 8'h10, 8'h11);       wait_done("mul");
      issue("mul2", 3'b111, 8'h0F, 8'h0D);      wait_done("mul2");

      // start while busy must be ignored
      issue("long_ign", long_op, 8'h10, long_b);
      @(negedge clk);
      chk("ign_busy", busy, 1'b1);
      start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      wait_done("long_ign");

      // reset in the middle of a long operation
      issue("long_rst", long_op, 8'h10, long_b);
      repeat (3) @(negedge clk);
      chk("mid_busy", busy, 1'b1);
      reset = 1'b1;
      q.delete();
      #1;
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_done", {done, load_flags}, 2'b00);
      chk("mrst_result", result, 8'h00);
      chk("mrst_flags", {Z_out, N_out, C_out, V_out}, 4'b0000);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("post_rst_idle", busy, 1'b0);
      issue("add_after", 3'b000, 8'h01, 8'h01); wait_done("add_after");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
